// File: rtl/tx_timing_axil_regs.sv
// AXI4-Lite register bank for tx_timing: NUM_REGS byte-strobed RW registers plus a 64-bit
// free-running timestamp whose high word is latched when the low word is read.
module tx_timing_axil_regs #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned ADDR_WIDTH = 6,
   parameter int unsigned NUM_REGS   = 4
) (
   input  logic                           s00_axi_aclk,
   input  logic                           s00_axi_aresetn,
   input  logic [ADDR_WIDTH-1:0]          s00_axi_awaddr,
   input  logic [2:0]                     s00_axi_awprot,
   input  logic                           s00_axi_awvalid,
   output logic                           s00_axi_awready,
   input  logic [DATA_WIDTH-1:0]          s00_axi_wdata,
   input  logic [DATA_WIDTH/8-1:0]        s00_axi_wstrb,
   input  logic                           s00_axi_wvalid,
   output logic                           s00_axi_wready,
   output logic [1:0]                     s00_axi_bresp,
   output logic                           s00_axi_bvalid,
   input  logic                           s00_axi_bready,
   input  logic [ADDR_WIDTH-1:0]          s00_axi_araddr,
   input  logic [2:0]                     s00_axi_arprot,
   input  logic                           s00_axi_arvalid,
   output logic                           s00_axi_arready,
   output logic [DATA_WIDTH-1:0]          s00_axi_rdata,
   output logic [1:0]                     s00_axi_rresp,
   output logic                           s00_axi_rvalid,
   input  logic                           s00_axi_rready,
   input  logic                           ts_en,
   output logic [NUM_REGS*DATA_WIDTH-1:0] reg_out,
   output logic [NUM_REGS-1:0]            reg_wr_pulse
);

   localparam int unsigned TS_WORDS = 64 / DATA_WIDTH;
   localparam int unsigned ADDR_LSB = $clog2(DATA_WIDTH / 8);
   localparam int unsigned STRB_W   = DATA_WIDTH / 8;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   logic                  rdy_en;
   logic                  aw_held;
   logic                  w_held;
   logic [31:0]           aw_idx;
   logic [DATA_WIDTH-1:0] w_data;
   logic [STRB_W-1:0]     w_strb;
   logic [DATA_WIDTH-1:0] regs [NUM_REGS];
   logic [63:0]           ts;
   logic [31:0]           ts_shadow;

   logic                  aw_hs;
   logic                  w_hs;
   logic                  ar_hs;
   logic                  commit;
   logic [31:0]           aw_word;
   logic [31:0]           ar_word;
   logic [DATA_WIDTH-1:0] rd_data;
   logic [1:0]            rd_resp;
   logic                  unused;

   assign unused = ^{s00_axi_awprot, s00_axi_arprot,
                     s00_axi_awaddr[ADDR_LSB-1:0], s00_axi_araddr[ADDR_LSB-1:0]};

   // rdy_en keeps every ready low until the first edge after reset release
   assign s00_axi_awready = rdy_en & ~aw_held & ~s00_axi_bvalid;
   assign s00_axi_wready  = rdy_en & ~w_held & ~s00_axi_bvalid;
   assign s00_axi_arready = rdy_en & ~s00_axi_rvalid;

   assign aw_hs  = s00_axi_awvalid & s00_axi_awready;
   assign w_hs   = s00_axi_wvalid & s00_axi_wready;
   assign ar_hs  = s00_axi_arvalid & s00_axi_arready;
   assign commit = aw_held & w_held;

   assign aw_word = 32'(s00_axi_awaddr[ADDR_WIDTH-1:ADDR_LSB]);
   assign ar_word = 32'(s00_axi_araddr[ADDR_WIDTH-1:ADDR_LSB]);

   always_comb begin
      rd_data = '0;
      rd_resp = RESP_SLVERR;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
         if (ar_word == 32'(k)) begin
            rd_data = regs[k];
            rd_resp = RESP_OKAY;
         end
      end
      if (ar_word >= NUM_REGS && ar_word < NUM_REGS + TS_WORDS) begin
         rd_resp = RESP_OKAY;
         rd_data = (ar_word == NUM_REGS) ? DATA_WIDTH'(ts) : DATA_WIDTH'(ts_shadow);
      end
   end

   always_comb begin
      reg_out = '0;
      for (int k = 0; k < int'(NUM_REGS); k++) begin
         reg_out[k*DATA_WIDTH +: DATA_WIDTH] = regs[k];
      end
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         rdy_en         <= 1'b0;
         aw_held        <= 1'b0;
         w_held         <= 1'b0;
         aw_idx         <= '0;
         w_data         <= '0;
         w_strb         <= '0;
         s00_axi_bvalid <= 1'b0;
         s00_axi_bresp  <= RESP_OKAY;
         reg_wr_pulse   <= '0;
         for (int k = 0; k < int'(NUM_REGS); k++) begin
            regs[k] <= '0;
         end
      end else begin
         rdy_en       <= 1'b1;
         reg_wr_pulse <= '0;
         if (aw_hs) begin
            aw_held <= 1'b1;
            aw_idx  <= aw_word;
         end
         if (w_hs) begin
            w_held <= 1'b1;
            w_data <= s00_axi_wdata;
            w_strb <= s00_axi_wstrb;
         end
         if (commit) begin
            aw_held        <= 1'b0;
            w_held         <= 1'b0;
            s00_axi_bvalid <= 1'b1;
            // timestamp words are read-only but acknowledged without error
            if (aw_idx < NUM_REGS + TS_WORDS) begin
               s00_axi_bresp <= RESP_OKAY;
            end else begin
               s00_axi_bresp <= RESP_SLVERR;
            end
            for (int k = 0; k < int'(NUM_REGS); k++) begin
               if (aw_idx == 32'(k)) begin
                  reg_wr_pulse[k] <= 1'b1;
                  for (int b = 0; b < int'(STRB_W); b++) begin
                     if (w_strb[b]) begin
                        regs[k][b*8 +: 8] <= w_data[b*8 +: 8];
                     end
                  end
               end
            end
         end else if (s00_axi_bvalid && s00_axi_bready) begin
            s00_axi_bvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         s00_axi_rvalid <= 1'b0;
         s00_axi_rdata  <= '0;
         s00_axi_rresp  <= RESP_OKAY;
         ts_shadow      <= '0;
      end else begin
         if (ar_hs) begin
            s00_axi_rvalid <= 1'b1;
            s00_axi_rdata  <= rd_data;
            s00_axi_rresp  <= rd_resp;
            // latch the high half with the low half so the pair reads atomically
            if (DATA_WIDTH == 32 && ar_word == NUM_REGS) begin
               ts_shadow <= ts[63:32];
            end
         end else if (s00_axi_rvalid && s00_axi_rready) begin
            s00_axi_rvalid <= 1'b0;
         end
      end
   end

   always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
      if (!s00_axi_aresetn) begin
         ts <= '0;
      end else if (ts_en) begin
         ts <= ts + 64'd1;
      end
   end

endmodule

// File: tb/tb_tx_timing_axil_regs.sv
// Directed bench for tx_timing_axil_regs (DW=32, NUM_REGS=4): writes, strobes, W-before-AW,
// out-of-range, timestamp atomic read, read/write collision and reset mid-transaction.
module tb_tx_timing_axil_regs;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [5:0]  awaddr;
   logic [2:0]  awprot;
   logic        awvalid;
   logic        awready;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wvalid;
   logic        wready;
   logic [1:0]  bresp;
   logic        bvalid;
   logic        bready;
   logic [5:0]  araddr;
   logic [2:0]  arprot;
   logic        arvalid;
   logic        arready;
   logic [31:0] rdata;
   logic [1:0]  rresp;
   logic        rvalid;
   logic        rready;
   logic        ts_en;
   logic [127:0] reg_out;
   logic [3:0]  reg_wr_pulse;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   tx_timing_axil_regs #(.DATA_WIDTH(32), .ADDR_WIDTH(6), .NUM_REGS(4)) dut (
      .s00_axi_aclk    (clk),
      .s00_axi_aresetn (rst_n),
      .s00_axi_awaddr  (awaddr),
      .s00_axi_awprot  (awprot),
      .s00_axi_awvalid (awvalid),
      .s00_axi_awready (awready),
      .s00_axi_wdata   (wdata),
      .s00_axi_wstrb   (wstrb),
      .s00_axi_wvalid  (wvalid),
      .s00_axi_wready  (wready),
      .s00_axi_bresp   (bresp),
      .s00_axi_bvalid  (bvalid),
      .s00_axi_bready  (bready),
      .s00_axi_araddr  (araddr),
      .s00_axi_arprot  (arprot),
      .s00_axi_arvalid (arvalid),
      .s00_axi_arready (arready),
      .s00_axi_rdata   (rdata),
      .s00_axi_rresp   (rresp),
      .s00_axi_rvalid  (rvalid),
      .s00_axi_rready  (rready),
      .ts_en           (ts_en),
      .reg_out         (reg_out),
      .reg_wr_pulse    (reg_wr_pulse)
   );

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // called at a negedge, returns at a negedge
   task automatic axi_write(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb,
                            output logic [1:0] resp, output logic [3:0] pulse);
      bit aw_done = 0;
      bit w_done = 0;
      bit aw_go, w_go;
      int n = 0;
      awaddr = addr; wdata = data; wstrb = strb;
      awvalid = 1'b1; wvalid = 1'b1;
      while (!(aw_done && w_done) && n < 20) begin
         aw_go = awvalid && awready;
         w_go  = wvalid && wready;
         @(posedge clk); #1;
         if (aw_go) begin awvalid = 1'b0; aw_done = 1; end
         if (w_go) begin wvalid = 1'b0; w_done = 1; end
         @(negedge clk);
         n++;
      end
      n = 0;
      while (!bvalid && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("write_bvalid_arrives", 128'(bvalid), 128'(1));
      resp  = bresp;
      pulse = reg_wr_pulse;
      bready = 1'b1;
      @(posedge clk); #1;
      bready = 1'b0; awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
   endtask

   task automatic axi_read(input logic [5:0] addr, output logic [31:0] data, output logic [1:0] resp);
      int n = 0;
      araddr = addr; arvalid = 1'b1;
      while (!arready && n < 20) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk); #1;
      arvalid = 1'b0;
      @(negedge clk);
      check("read_rvalid_arrives", 128'(rvalid), 128'(1));
      data = rdata;
      resp = rresp;
      rready = 1'b1;
      @(posedge clk); #1;
      rready = 1'b0;
      @(negedge clk);
   endtask

   logic [1:0]  resp;
   logic [3:0]  pulse;
   logic [31:0] rd;

   initial begin
      rst_n = 1'b0;
      awaddr = '0; awprot = '0; awvalid = 1'b0;
      wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b0;
      araddr = '0; arprot = '0; arvalid = 1'b0; rready = 1'b0;
      ts_en = 1'b0;
      repeat (3) @(negedge clk);

      check("rst_awready", 128'(awready), 128'(0));
      check("rst_wready", 128'(wready), 128'(0));
      check("rst_arready", 128'(arready), 128'(0));
      check("rst_bvalid", 128'(bvalid), 128'(0));
      check("rst_rvalid", 128'(rvalid), 128'(0));
      check("rst_rdata", 128'(rdata), 128'(0));
      check("rst_reg_out", reg_out, 128'(0));
      check("rst_pulse", 128'(reg_wr_pulse), 128'(0));

      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_awready", 128'(awready), 128'(1));
      check("post_rst_wready", 128'(wready), 128'(1));
      check("post_rst_arready", 128'(arready), 128'(1));

      // 1: write 1..4 to regs 0..3 and read back
      for (int k = 0; k < 4; k++) begin
         axi_write(6'(k * 4), 32'(k + 1), 4'hF, resp, pulse);
         check($sformatf("t1_bresp_%0d", k), 128'(resp), 128'(0));
         check($sformatf("t1_pulse_%0d", k), 128'(pulse), 128'(4'b0001 << k));
         check($sformatf("t1_pulse_clear_%0d", k), 128'(reg_wr_pulse), 128'(0));
      end
      check("t1_reg_out", reg_out, 128'h00000004_00000003_00000002_00000001);
      for (int k = 0; k < 4; k++) begin
         axi_read(6'(k * 4), rd, resp);
         check($sformatf("t1_rdata_%0d", k), 128'(rd), 128'(k + 1));
         check($sformatf("t1_rresp_%0d", k), 128'(resp), 128'(0));
      end

      // 2: byte strobes
      axi_write(6'h00, 32'h11223344, 4'hF, resp, pulse);
      axi_write(6'h00, 32'hAABBCCDD, 4'b0101, resp, pulse);
      check("t2_pulse", 128'(pulse), 128'(4'b0001));
      axi_read(6'h00, rd, resp);
      check("t2_rdata", 128'(rd), 128'(32'h11BB33DD));
      axi_write(6'h00, 32'hFFFFFFFF, 4'b0000, resp, pulse);
      check("t2_zero_strb_resp", 128'(resp), 128'(0));
      check("t2_zero_strb_pulse", 128'(pulse), 128'(4'b0001));
      check("t2_zero_strb_data", 128'(reg_out[31:0]), 128'(32'h11BB33DD));

      // 3: W three cycles before AW
      awaddr = 6'h04; wdata = 32'hCAFE0001; wstrb = 4'hF; wvalid = 1'b1;
      check("t3_wready_before", 128'(wready), 128'(1));
      @(posedge clk); #1; wvalid = 1'b0;
      @(negedge clk);
      check("t3_wready_dropped", 128'(wready), 128'(0));
      @(negedge clk);
      @(negedge clk);
      check("t3_no_early_bvalid", 128'(bvalid), 128'(0));
      check("t3_no_early_write", 128'(reg_out[63:32]), 128'(2));
      awvalid = 1'b1;
      check("t3_awready", 128'(awready), 128'(1));
      @(posedge clk); #1; awvalid = 1'b0;
      @(negedge clk);
      check("t3_bvalid_not_yet", 128'(bvalid), 128'(0));
      @(negedge clk);
      check("t3_bvalid", 128'(bvalid), 128'(1));
      check("t3_pulse", 128'(reg_wr_pulse), 128'(4'b0010));
      check("t3_reg1", 128'(reg_out[63:32]), 128'(32'hCAFE0001));
      bready = 1'b1;
      @(posedge clk); #1; bready = 1'b0;
      @(negedge clk);
      check("t3_bvalid_cleared", 128'(bvalid), 128'(0));
      check("t3_single_pulse", 128'(reg_wr_pulse), 128'(0));

      // 4: out-of-range and read-only timestamp word
      axi_write(6'h18, 32'hDEADBEEF, 4'hF, resp, pulse);
      check("t4_bresp", 128'(resp), 128'(2'b10));
      check("t4_pulse", 128'(pulse), 128'(0));
      check("t4_regs", reg_out, 128'h00000004_00000003_CAFE0001_11BB33DD);
      axi_read(6'h18, rd, resp);
      check("t4_rdata", 128'(rd), 128'(0));
      check("t4_rresp", 128'(resp), 128'(2'b10));
      axi_write(6'h10, 32'h12345678, 4'hF, resp, pulse);
      check("t4_ts_bresp", 128'(resp), 128'(0));
      check("t4_ts_pulse", 128'(pulse), 128'(0));

      // 5a: timestamp counts exactly the enabled cycles
      ts_en = 1'b1;
      repeat (5) @(posedge clk);
      #1; ts_en = 1'b0;
      @(negedge clk);
      axi_read(6'h10, rd, resp);
      check("t5_ts_lo_count", 128'(rd), 128'(5));
      check("t5_ts_lo_resp", 128'(resp), 128'(0));
      axi_read(6'h14, rd, resp);
      check("t5_ts_hi_count", 128'(rd), 128'(0));

      // 5b: high word comes from the shadow latched at the low-word read
      force dut.ts = 64'h0000_0001_FFFF_FFFF;
      ts_en = 1'b1;
      axi_read(6'h10, rd, resp);
      check("t5_ts_lo", 128'(rd), 128'(32'hFFFFFFFF));
      release dut.ts;
      repeat (3) @(negedge clk);
      axi_read(6'h14, rd, resp);
      check("t5_ts_hi", 128'(rd), 128'(32'h00000001));
      ts_en = 1'b0;

      // read sampled on the commit edge returns the pre-write value
      awaddr = 6'h08; wdata = 32'h00000055; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      araddr = 6'h08; arvalid = 1'b1;
      @(posedge clk); #1; arvalid = 1'b0;
      @(negedge clk);
      check("coll_rvalid", 128'(rvalid), 128'(1));
      check("coll_rdata_old", 128'(rdata), 128'(3));
      check("coll_bvalid", 128'(bvalid), 128'(1));
      check("coll_reg2_new", 128'(reg_out[95:64]), 128'(32'h55));
      rready = 1'b1; bready = 1'b1;
      @(posedge clk); #1; rready = 1'b0; bready = 1'b0;
      @(negedge clk);

      // 6: bready stalled, then reset mid-stall with a read also pending
      awaddr = 6'h0C; wdata = 32'h99; wstrb = 4'hF;
      awvalid = 1'b1; wvalid = 1'b1;
      @(posedge clk); #1; awvalid = 1'b0; wvalid = 1'b0;
      @(negedge clk);
      araddr = 6'h00; arvalid = 1'b1;
      @(posedge clk); #1; arvalid = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         check($sformatf("t6_stall_%0d", c), 128'({bvalid, awready, wready}), 128'(3'b100));
      end
      check("t6_rvalid_held", 128'(rvalid), 128'(1));
      rst_n = 1'b0;
      #1;
      check("t6_rst_bvalid", 128'(bvalid), 128'(0));
      check("t6_rst_rvalid", 128'(rvalid), 128'(0));
      check("t6_rst_readys", 128'({awready, wready, arready}), 128'(0));
      check("t6_rst_regs", reg_out, 128'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("t6_post_awready", 128'(awready), 128'(1));
      check("t6_post_bvalid", 128'(bvalid), 128'(0));
      axi_read(6'h0C, rd, resp);
      check("t6_no_partial_write", 128'(rd), 128'(0));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
